// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Shared types for the 4-bit CPU instruction path:
//     instr_t    - one 8-bit instruction word {opecode, imm}
//     ld_state_t - program-loader session state
//     INSTR_NOP  - reset value of every instruction word (ADD A,0)
// ---------------------------------------------------------------------------
package cpu_pkg;

   typedef struct packed {
      logic [3:0] opecode;
      logic [3:0] imm;
   } instr_t;

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_HI   = 2'd1,
      LD_LO   = 2'd2
   } ld_state_t;

   localparam instr_t INSTR_NOP = '0;

endpackage : cpu_pkg

// File: rtl/prog_mem_loader.sv
// ---------------------------------------------------------------------------
// prog_mem_loader
//   Instruction memory for the 4-bit CPU with a nibble-stream program loader.
//   The CPU fetches {opecode, imm} combinationally at addr. A host loads a
//   program as high/low nibble pairs over a valid/ready handshake; while a
//   session is open cpu_hold keeps the CPU in reset.
//
// Ports
//   clk       in   1         rising-edge clock
//   rst       in   1         asynchronous active-high reset (clears memory)
//   addr      in   ADDR_W    fetch address
//   opecode   out  4         mem[addr] opcode
//   imm       out  4         mem[addr] immediate
//   ld_start  in   1         open / restart a load session
//   ld_valid  in   1         host nibble valid
//   ld_data   in   4         host nibble
//   ld_last   in   1         final word marker, sampled with the low nibble
//   ld_ready  out  1         loader accepts a nibble
//   cpu_hold  out  1         session open, CPU held in reset
//   words     out  ADDR_W+1  words written in the current/last session
// ---------------------------------------------------------------------------
module prog_mem_loader
   import cpu_pkg::*;
#(
   parameter  int ADDR_W = 4,
   localparam int DEPTH  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   output logic [3:0]        opecode,
   output logic [3:0]        imm,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [3:0]        ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              cpu_hold,
   output logic [ADDR_W:0]   words
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   WORD_ONE  = (ADDR_W + 1)'(1);

   ld_state_t         state_q, state_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W:0]   words_q, words_d;
   logic [3:0]        hi_q, hi_d;
   logic              we_s;
   logic              ready_s;
   logic              accept_s;
   instr_t            mem_q [DEPTH];
   instr_t            fetch_s;

   // Handshake outputs come straight from the state register so they never glitch.
   always_comb begin
      ready_s = 1'b0;
      case (state_q)
         LD_HI:   ready_s = 1'b1;
         LD_LO:   ready_s = 1'b1;
         default: ready_s = 1'b0;
      endcase
   end

   assign accept_s = ld_valid & ready_s;
   assign ld_ready = ready_s;
   assign cpu_hold = ready_s;
   assign words    = words_q;

   // Loader next-state: start/restart beats any same-cycle accept.
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      words_d = words_q;
      hi_d    = hi_q;
      we_s    = 1'b0;
      case (state_q)
         LD_IDLE: begin
            if (ld_start) begin
               state_d = LD_HI;
               wptr_d  = '0;
               words_d = '0;
            end else begin
               state_d = LD_IDLE;
            end
         end
         LD_HI: begin
            if (ld_start) begin
               state_d = LD_HI;
               wptr_d  = '0;
               words_d = '0;
            end else if (accept_s) begin
               hi_d    = ld_data;
               state_d = LD_LO;
            end else begin
               state_d = LD_HI;
            end
         end
         LD_LO: begin
            if (ld_start) begin
               state_d = LD_HI;
               wptr_d  = '0;
               words_d = '0;
            end else if (accept_s) begin
               we_s    = 1'b1;
               words_d = words_q + WORD_ONE;
               // The last slot closes the session; wptr parks there instead of wrapping.
               if (ld_last || (wptr_q == LAST_ADDR)) begin
                  state_d = LD_IDLE;
               end else begin
                  state_d = LD_HI;
               end
               if (wptr_q == LAST_ADDR) begin
                  wptr_d = wptr_q;
               end else begin
                  wptr_d = wptr_q + ADDR_ONE;
               end
            end else begin
               state_d = LD_LO;
            end
         end
         default: begin
            state_d = LD_IDLE;
         end
      endcase
   end

   // Loader state, pointer, counter and high-nibble holding register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LD_IDLE;
         wptr_q  <= '0;
         words_q <= '0;
         hi_q    <= 4'h0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         words_q <= words_d;
         hi_q    <= hi_d;
      end
   end

   // Instruction memory; reset wipes any partially loaded program.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= INSTR_NOP;
         end
      end else if (we_s) begin
         mem_q[wptr_q] <= {hi_q, ld_data};
      end
   end

   assign fetch_s = mem_q[addr];
   assign opecode = fetch_s.opecode;
   assign imm     = fetch_s.imm;

endmodule : prog_mem_loader
